uart_tx_buffer: RTL and testbench

//  Byte FIFO and frame sequencer placed directly upstream of the UART transmitter.

---
 rtl/uart_tx_buffer_if.sv | 38 +++
 rtl/uart_tx_buffer.sv | 162 ++++++++++++++++
 tb/tb_uart_tx_buffer.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_buffer_if.sv
// Producer/transmitter-side signal bundle for uart_tx_buffer; ovf/ovf_clr exist only with UART_TX_OVF_FLAG_EN.
// The master modport drives writes and txd_flag, and the slave modport is the buffer itself.
interface uart_tx_buffer_if #(
  parameter int DEPTH_LOG2 = 4
);
  logic                  wr_en;
  logic [7:0]            wr_data;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   level;
  logic                  busy;
  logic                  txd_en;
  logic [7:0]            txd_data;
  logic                  txd_flag;
  logic                  tx_timeout;
`ifdef UART_TX_OVF_FLAG_EN
  logic                  ovf_clr;
  logic                  ovf;

  modport master (
    output wr_en, wr_data, txd_flag, ovf_clr,
    input  full, empty, level, busy, txd_en, txd_data, tx_timeout, ovf
  );
  modport slave (
    input  wr_en, wr_data, txd_flag, ovf_clr,
    output full, empty, level, busy, txd_en, txd_data, tx_timeout, ovf
  );
`else
  modport master (
    output wr_en, wr_data, txd_flag,
    input  full, empty, level, busy, txd_en, txd_data, tx_timeout
  );
  modport slave (
    input  wr_en, wr_data, txd_flag,
    output full, empty, level, busy, txd_en, txd_data, tx_timeout
  );
`endif
endinterface

// File: rtl/uart_tx_buffer.sv
// Byte FIFO and frame sequencer ahead of the UART transmitter. UART_TX_OVF_FLAG_EN adds a sticky overflow flag.
// A push at edge N gives txd_en after edge N+1. Writes that arrive while the FIFO is full are dropped.
module uart_tx_buffer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int GAP_CYCLES = 0,
  parameter int TX_TIMEOUT = 200000
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_buffer_if.slave  bus
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int WDOG_W  = (TX_TIMEOUT > 1) ? $clog2(TX_TIMEOUT) : 1;
  localparam int GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int WDOG_LI = (TX_TIMEOUT > 0) ? TX_TIMEOUT - 1 : 0;
  localparam int GAP_LI  = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  localparam logic [DEPTH_LOG2:0] LVL_FULL  = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_ZERO  = '0;
  localparam logic [WDOG_W-1:0]   WDOG_LAST = WDOG_W'(WDOG_LI);
  localparam logic [GAP_W-1:0]    GAP_LAST  = GAP_W'(GAP_LI);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_level;
  logic                  r_full;
  logic                  r_empty;

  logic [1:0]            r_state;
  logic [WDOG_W-1:0]     r_wdog;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic                  r_txd_en;
  logic [7:0]            r_txd_data;
  logic                  r_tx_timeout;

  logic                  w_push;
  logic                  w_pop;
  logic [DEPTH_LOG2:0]   w_level_nxt;
  logic [7:0]            w_head;

  // Acceptance looks only at the registered full flag, so a pop in the same cycle cannot rescue a write.
  assign w_push = bus.wr_en && !r_full;
  assign w_pop  = (r_state == S_IDLE) && !r_empty;
  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    w_level_nxt = r_level;
    case ({w_push, w_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == LVL_FULL);
      r_empty <= (w_level_nxt == LVL_ZERO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_wdog       <= '0;
      r_gap_cnt    <= '0;
      r_txd_en     <= 1'b0;
      r_txd_data   <= 8'h00;
      r_tx_timeout <= 1'b0;
    end else begin
      r_txd_en     <= 1'b0;
      r_tx_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!r_empty) begin
            r_txd_data <= w_head;
            r_txd_en   <= 1'b1;
            r_wdog     <= '0;
            r_state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          // A txd_flag in the txd_en cycle belongs to no frame of ours, and a flag wins over a coinciding timeout.
          if (bus.txd_flag && !r_txd_en) begin
            r_gap_cnt <= '0;
            if (GAP_CYCLES > 0) begin
              r_state <= S_GAP;
            end else begin
              r_state <= S_IDLE;
            end
          end else if (r_wdog == WDOG_LAST) begin
            r_tx_timeout <= 1'b1;
            r_state      <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef UART_TX_OVF_FLAG_EN
  logic r_ovf;
  logic w_ovf_set;

  assign w_ovf_set = bus.wr_en && r_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else if (bus.ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.full       = r_full;
  assign bus.empty      = r_empty;
  assign bus.level      = r_level;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.txd_en     = r_txd_en;
  assign bus.txd_data   = r_txd_data;
  assign bus.tx_timeout = r_tx_timeout;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer: a default instance, a GAP_CYCLES=3 instance and a TX_TIMEOUT=20 instance.
// The overflow-flag steps are built only when UART_TX_OVF_FLAG_EN is defined.
module tb_uart_tx_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_buffer_if #(.DEPTH_LOG2(4)) ba ();
  uart_tx_buffer_if #(.DEPTH_LOG2(4)) bb ();
  uart_tx_buffer_if #(.DEPTH_LOG2(4)) bc ();

  uart_tx_buffer #(.DEPTH_LOG2(4), .GAP_CYCLES(0), .TX_TIMEOUT(200000)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ba));
  uart_tx_buffer #(.DEPTH_LOG2(4), .GAP_CYCLES(3), .TX_TIMEOUT(200000)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bb));
  uart_tx_buffer #(.DEPTH_LOG2(4), .GAP_CYCLES(0), .TX_TIMEOUT(20)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(bc));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    ba.wr_en = 1'b0; ba.wr_data = 8'h00; ba.txd_flag = 1'b0;
    bb.wr_en = 1'b0; bb.wr_data = 8'h00; bb.txd_flag = 1'b0;
    bc.wr_en = 1'b0; bc.wr_data = 8'h00; bc.txd_flag = 1'b0;
`ifdef UART_TX_OVF_FLAG_EN
    ba.ovf_clr = 1'b0; bb.ovf_clr = 1'b0; bc.ovf_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", 32'(ba.level), 32'd0);
    check("rst_full", 32'(ba.full), 32'd0);
    check("rst_empty", 32'(ba.empty), 32'd1);
    check("rst_busy", 32'(ba.busy), 32'd0);
    check("rst_txd_en", 32'(ba.txd_en), 32'd0);
    check("rst_txd_data", 32'(ba.txd_data), 32'h00);
    check("rst_timeout", 32'(ba.tx_timeout), 32'd0);
`ifdef UART_TX_OVF_FLAG_EN
    check("rst_ovf", 32'(ba.ovf), 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Single byte: no fall-through, txd_en one cycle later, flag in the txd_en cycle ignored
    ba.wr_en = 1'b1; ba.wr_data = 8'hA5;
    tick();
    ba.wr_en = 1'b0;
    check("t1_no_fallthru", 32'(ba.txd_en), 32'd0);
    check("t1_level1", 32'(ba.level), 32'd1);
    tick();
    check("t1_txd_en", 32'(ba.txd_en), 32'd1);
    check("t1_txd_data", 32'(ba.txd_data), 32'hA5);
    check("t1_busy", 32'(ba.busy), 32'd1);
    check("t1_empty_pop", 32'(ba.empty), 32'd1);
    ba.txd_flag = 1'b1;
    tick();
    ba.txd_flag = 1'b0;
    check("t1_flag_in_en_ignored", 32'(ba.busy), 32'd1);
    check("t1_en_one_cycle", 32'(ba.txd_en), 32'd0);
    repeat (48) tick();
    check("t1_still_busy", 32'(ba.busy), 32'd1);
    check("t1_data_stable", 32'(ba.txd_data), 32'hA5);
    ba.txd_flag = 1'b1;
    tick();
    ba.txd_flag = 1'b0;
    check("t1_done_busy", 32'(ba.busy), 32'd0);
    check("t1_done_empty", 32'(ba.empty), 32'd1);

    // Burst fill: 16 bytes, then one accepted and one dropped
    for (int i = 0; i < 16; i++) begin
      ba.wr_en = 1'b1; ba.wr_data = 8'(i);
      tick();
    end
    check("t2_level15", 32'(ba.level), 32'd15);
    check("t2_not_full", 32'(ba.full), 32'd0);
    check("t2_inflight", 32'(ba.txd_data), 32'h00);
    ba.wr_data = 8'h10;
    tick();
    check("t2_level16", 32'(ba.level), 32'd16);
    check("t2_full", 32'(ba.full), 32'd1);
    ba.wr_data = 8'h11;
    tick();
    ba.wr_en = 1'b0;
    check("t2_drop_level", 32'(ba.level), 32'd16);
    check("t2_drop_full", 32'(ba.full), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      ba.txd_flag = 1'b1;
      tick();
      ba.txd_flag = 1'b0;
      check($sformatf("t2_gap0_idle_%0d", k), 32'(ba.txd_en), 32'd0);
      tick();
      check($sformatf("t2_en_%0d", k), 32'(ba.txd_en), 32'd1);
      check($sformatf("t2_data_%0d", k), 32'(ba.txd_data), 32'(k));
      tick();
    end
    check("t2_all_popped", 32'(ba.empty), 32'd1);
    ba.txd_flag = 1'b1;
    tick();
    ba.txd_flag = 1'b0;
    check("t2_end_busy", 32'(ba.busy), 32'd0);
    check("t2_end_level", 32'(ba.level), 32'd0);

    // Gap of 3: txd_en for the second byte exactly 5 cycles after the flag
    bb.wr_en = 1'b1; bb.wr_data = 8'h11;
    tick();
    bb.wr_data = 8'h22;
    tick();
    bb.wr_en = 1'b0;
    check("t3_first_en", 32'(bb.txd_en), 32'd1);
    check("t3_first_data", 32'(bb.txd_data), 32'h11);
    tick();
    bb.txd_flag = 1'b1;
    tick();
    bb.txd_flag = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      check($sformatf("t3_no_en_c%0d", j), 32'(bb.txd_en), 32'd0);
      check($sformatf("t3_busy_c%0d", j), 32'(bb.busy), (j < 4) ? 32'd1 : 32'd0);
      tick();
    end
    check("t3_en_c5", 32'(bb.txd_en), 32'd1);
    check("t3_data_c5", 32'(bb.txd_data), 32'h22);

    // Watchdog of 20: timeout pulse, next byte, then flag beats a coinciding timeout
    bc.wr_en = 1'b1; bc.wr_data = 8'h3C;
    tick();
    bc.wr_data = 8'h5A;
    tick();
    bc.wr_en = 1'b0;
    check("t4_en", 32'(bc.txd_en), 32'd1);
    check("t4_data", 32'(bc.txd_data), 32'h3C);
    for (int j = 1; j <= 19; j++) begin
      tick();
      check($sformatf("t4_no_to_%0d", j), 32'(bc.tx_timeout), 32'd0);
    end
    tick();
    check("t4_timeout_pulse", 32'(bc.tx_timeout), 32'd1);
    check("t4_idle", 32'(bc.busy), 32'd0);
    tick();
    check("t4_timeout_one_cycle", 32'(bc.tx_timeout), 32'd0);
    check("t4_next_en", 32'(bc.txd_en), 32'd1);
    check("t4_next_data", 32'(bc.txd_data), 32'h5A);
    repeat (19) tick();
    bc.txd_flag = 1'b1;
    tick();
    bc.txd_flag = 1'b0;
    check("t4_flag_wins_to", 32'(bc.tx_timeout), 32'd0);
    check("t4_flag_wins_idle", 32'(bc.busy), 32'd0);

    // Reset asserted during WAIT with four bytes queued
    for (int i = 0; i < 5; i++) begin
      ba.wr_en = 1'b1; ba.wr_data = 8'hC0 + 8'(i);
      tick();
    end
    ba.wr_en = 1'b0;
    check("t5_level4", 32'(ba.level), 32'd4);
    check("t5_busy", 32'(ba.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_rst_level", 32'(ba.level), 32'd0);
    check("t5_rst_empty", 32'(ba.empty), 32'd1);
    check("t5_rst_busy", 32'(ba.busy), 32'd0);
    check("t5_rst_data", 32'(ba.txd_data), 32'h00);
    check("t5_rst_b_busy", 32'(bb.busy), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) begin
      tick();
      check($sformatf("t5_no_en_%0d", j), 32'(ba.txd_en), 32'd0);
    end
    check("t5_post_empty", 32'(ba.empty), 32'd1);

`ifdef UART_TX_OVF_FLAG_EN
    // Sticky overflow: set, hold, clear, and set winning over a same-cycle clear
    for (int i = 0; i < 17; i++) begin
      ba.wr_en = 1'b1; ba.wr_data = 8'(i);
      tick();
    end
    check("t6_full", 32'(ba.full), 32'd1);
    check("t6_no_ovf_yet", 32'(ba.ovf), 32'd0);
    tick();
    ba.wr_en = 1'b0;
    check("t6_ovf_set", 32'(ba.ovf), 32'd1);
    repeat (2) tick();
    check("t6_ovf_held", 32'(ba.ovf), 32'd1);
    ba.ovf_clr = 1'b1;
    tick();
    ba.ovf_clr = 1'b0;
    check("t6_ovf_cleared", 32'(ba.ovf), 32'd0);
    ba.wr_en = 1'b1; ba.ovf_clr = 1'b1;
    tick();
    ba.wr_en = 1'b0; ba.ovf_clr = 1'b0;
    check("t6_set_beats_clr", 32'(ba.ovf), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
